grid_lookup_arbiter: RTL and testbench
======================================

Name: grid_lookup_arbiter

Overview:
Shares the single-port wall-map ROM (grid, 32x24 cells, 20 px per cell, 1 wall bit per cell) between several movers: the player and the enemy/sprite controllers. Each mover posts a candidate cell address and receives a registered wall/free answer.
- Round-robin arbitration; one lookup in flight at a time.
- Sits between the mover modules and the grid ROM in the top level.
- Replaces per-mover direct ROM instances, which cannot share one ROM port.

Parameters:
NUM_REQ, 4, number of requesters; requester 0 is the player.
ADDR_W, 10, cell address width (row*32 + col).
ROM_LAT, 1, grid ROM read latency in clocks (legal values 1..3).

Ports:
Clk  input  1  system clock
Reset  input  1  asynchronous, active-high reset
req  input  NUM_REQ  per-requester lookup request (level)
req_addr  input  NUM_REQ*ADDR_W  packed cell addresses; requester i uses slice [i*ADDR_W +: ADDR_W]
rsp_valid  output  NUM_REQ  one-cycle pulse: answer for requester i
rsp_wall  output  1  wall bit, valid while any rsp_valid bit is set
rom_addr  output  ADDR_W  address to grid ROM
rom_data  input  1  grid ROM wall bit, ROM_LAT cycles after rom_addr
busy  output  1  high while a lookup is in flight
lookup_cnt  output  16  total completed lookups (feature-gated)
wall_cnt  output  16  lookups that returned wall=1 (feature-gated)

Behaviour:
- Reset (async) values: state IDLE, rsp_valid=0, rsp_wall=0, rom_addr=0, busy=0, rr pointer=0, counters=0.
- Handshake:
  - Requester raises req[i] and holds req_addr stable until it sees rsp_valid[i].
  - The requester must drop req[i] in the cycle after rsp_valid[i]. Otherwise it is treated as a new request, eligible for arbitration no sooner than 1 cycle after the pulse.
- FSM states: IDLE, WAIT, RESP.
  - IDLE: if any req bit is set, pick the winner by round robin, starting at pointer and searching upward with wrap. Latch the winner index and address, drive rom_addr, busy=1, go to WAIT with wait counter = ROM_LAT-1.
  - WAIT: decrement the counter. At 0, capture rom_data into rsp_wall and go to RESP.
  - RESP: pulse rsp_valid[winner] for 1 cycle, set pointer = winner+1 mod NUM_REQ, busy=0, return to IDLE.
- Latency: req seen in IDLE at cycle t gives rsp_valid at cycle t+ROM_LAT+1.
- Throughput: one lookup per ROM_LAT+2 cycles.
- Out-of-range address (addr >= 768):
  - No ROM access; rom_addr holds its previous value.
  - Go straight from IDLE to RESP with rsp_wall=1, so the map edge acts as a wall.
  - Latency is 1 cycle.
- Requester drops req mid-lookup: the lookup completes and rsp_valid is still pulsed; the requester ignores it.
- Address changes mid-lookup: ignored; the latched address is used.
- Simultaneous requests: exactly one grant per lookup. A requester that stays asserted is served within NUM_REQ lookups.
- Reset mid-lookup: abort immediately. No rsp_valid pulse is issued for the aborted lookup.
- rsp_valid is one-hot or zero at all times.

Optional Feature:
GRID_ARB_STATS_EN
- Defined: lookup_cnt increments on each rsp_valid pulse; wall_cnt increments when that pulse carries rsp_wall=1. Both saturate at 16'hFFFF and clear only on Reset.
- Undefined: no counter flops; lookup_cnt and wall_cnt are tied to 0.
- Ports exist in both builds.

Decomposition:
- Package grid_pkg:
  - GRID_COLS=32, GRID_ROWS=24, CELL_PX=20, GRID_CELLS=768.
  - Typedef cell_addr_t (logic [9:0]).
  - Enum arb_state_t {IDLE, WAIT, RESP}.
- Sub-module rr_pick: combinational round-robin selector.
  - Inputs: req vector, pointer.
  - Outputs: one-hot grant, binary index, any-valid.
  - Instantiated once. The FSM, counters and latches stay in grid_lookup_arbiter.

Test Plan:
- Single request: req=4'b0001, addr=10'd37, ROM cell 37=1, ROM_LAT=1 -> rom_addr=37 at t+1, rsp_valid=4'b0001 with rsp_wall=1 at t+2, busy low at t+3.
- All four request together, pointer=0, held continuously -> grants in order 0,1,2,3,0, one grant per 3 cycles. Never two rsp_valid bits set at once.
- Out-of-range: req[2] with addr=10'd800 -> rsp_valid=4'b0100, rsp_wall=1 one cycle later. rom_addr unchanged.
- Mid-op events: req[1] dropped in WAIT -> rsp_valid[1] still pulses. Reset asserted in WAIT -> all outputs 0 immediately, no pulse after Reset deasserts, next grant goes to requester 0.
- ROM_LAT=3, addr=10'd0, ROM cell 0=0 -> rsp_valid 4 cycles after the request is seen, rsp_wall=0.
- GRID_ARB_STATS_EN defined, 5 lookups with 2 walls -> lookup_cnt=5, wall_cnt=2. Undefined -> both read 0.

Source files
------------

// File: rtl/grid_pkg.sv
// Shared wall-map constants and types for the grid lookup arbiter.
package grid_pkg;

  localparam int GRID_COLS  = 32;
  localparam int GRID_ROWS  = 24;
  localparam int CELL_PX    = 20;
  localparam int GRID_CELLS = GRID_COLS * GRID_ROWS;

  typedef logic [9:0] cell_addr_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } arb_state_t;

  // Cells past the last row are off the map and read back as walls.
  function automatic logic cell_on_map(input cell_addr_t addr);
    return addr < cell_addr_t'(GRID_CELLS);
  endfunction

endpackage

// File: rtl/grid_lookup_arbiter_rr_pick.sv
// Combinational round-robin selector: first set request at or above ptr, wrapping.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int PTR_W   = 2
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [PTR_W-1:0]   ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [PTR_W-1:0]   idx,
  output logic               any
);

  always_comb begin
    int cand;
    grant = '0;
    idx   = '0;
    any   = 1'b0;
    cand  = 0;
    for (int k = 0; k < NUM_REQ; k++) begin
      cand = (int'(ptr) + k) % NUM_REQ;
      if (!any && req[cand]) begin
        any         = 1'b1;
        grant[cand] = 1'b1;
        idx         = PTR_W'(cand);
      end
    end
  end

endmodule

// File: rtl/grid_lookup_arbiter.sv
// Round-robin sharing of the single-port wall-map ROM among movers.
// Optional GRID_ARB_STATS_EN adds saturating lookup/wall counters.
module grid_lookup_arbiter
  import grid_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int ADDR_W  = 10,
  parameter int ROM_LAT = 1
) (
  input  logic                      Clk,
  input  logic                      Reset,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*ADDR_W-1:0] req_addr,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic                      rsp_wall,
  output logic [ADDR_W-1:0]         rom_addr,
  input  logic                      rom_data,
  output logic                      busy,
  output logic [15:0]               lookup_cnt,
  output logic [15:0]               wall_cnt
);

  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CNT_W = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;

  arb_state_t         state;
  logic [PTR_W-1:0]   ptr;
  logic [NUM_REQ-1:0] win_oh;
  logic [PTR_W-1:0]   win_idx;
  logic [CNT_W-1:0]   wait_cnt;

  logic [NUM_REQ-1:0] pick_grant;
  logic [PTR_W-1:0]   pick_idx;
  logic               pick_any;
  logic [ADDR_W-1:0]  sel_addr;
  logic               sel_off_map;

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .PTR_W   (PTR_W)
  ) u_rr_pick (
    .req   (req),
    .ptr   (ptr),
    .grant (pick_grant),
    .idx   (pick_idx),
    .any   (pick_any)
  );

  assign sel_addr    = req_addr[pick_idx*ADDR_W +: ADDR_W];
  assign sel_off_map = (sel_addr >= ADDR_W'(GRID_CELLS));

  // rom_addr is the ROM's address stage, so the wait count starts at ROM_LAT-1.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state     <= IDLE;
      ptr       <= '0;
      win_oh    <= '0;
      win_idx   <= '0;
      wait_cnt  <= '0;
      rsp_valid <= '0;
      rsp_wall  <= 1'b0;
      rom_addr  <= '0;
      busy      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_any) begin
            win_oh  <= pick_grant;
            win_idx <= pick_idx;
            busy    <= 1'b1;
            if (sel_off_map) begin
              rsp_wall  <= 1'b1;
              rsp_valid <= pick_grant;
              state     <= RESP;
            end else begin
              rom_addr <= sel_addr;
              wait_cnt <= CNT_W'(ROM_LAT - 1);
              state    <= WAIT;
            end
          end
        end
        WAIT: begin
          if (wait_cnt == '0) begin
            rsp_wall  <= rom_data;
            rsp_valid <= win_oh;
            state     <= RESP;
          end else begin
            wait_cnt <= wait_cnt - 1'b1;
          end
        end
        RESP: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          ptr       <= (int'(win_idx) == NUM_REQ - 1) ? '0 : win_idx + 1'b1;
          state     <= IDLE;
        end
        default: begin
          rsp_valid <= '0;
          busy      <= 1'b0;
          state     <= IDLE;
        end
      endcase
    end
  end

`ifdef GRID_ARB_STATS_EN
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      lookup_cnt <= '0;
      wall_cnt   <= '0;
    end else if (|rsp_valid) begin
      if (lookup_cnt != 16'hFFFF) lookup_cnt <= lookup_cnt + 1'b1;
      if (rsp_wall && (wall_cnt != 16'hFFFF)) wall_cnt <= wall_cnt + 1'b1;
    end
  end
`else
  assign lookup_cnt = '0;
  assign wall_cnt   = '0;
`endif

endmodule

// File: tb/tb_grid_lookup_arbiter.sv
// Directed bench for grid_lookup_arbiter: one instance at ROM_LAT=1, one at ROM_LAT=3.
module tb_grid_lookup_arbiter;

  logic        clk;
  logic        rst;

  logic [3:0]  req_a;
  logic [39:0] addr_a;
  logic [3:0]  rsp_valid_a;
  logic        rsp_wall_a;
  logic [9:0]  rom_addr_a;
  logic        rom_data_a;
  logic        busy_a;
  logic [15:0] lookup_cnt_a;
  logic [15:0] wall_cnt_a;

  logic [3:0]  req_b;
  logic [39:0] addr_b;
  logic [3:0]  rsp_valid_b;
  logic        rsp_wall_b;
  logic [9:0]  rom_addr_b;
  logic        rom_data_b;
  logic        busy_b;
  logic [15:0] lookup_cnt_b;
  logic [15:0] wall_cnt_b;
  logic        rom_s1_b;

  int errors = 0;
  int checks = 0;

  // Map content: wall where bit0 xor bit3 (cell 37 = wall, cell 0 = free).
  function automatic logic rom_bit(input logic [9:0] a);
    return a[0] ^ a[3];
  endfunction

  assign rom_data_a = rom_bit(rom_addr_a);

  always @(posedge clk) begin
    rom_s1_b   <= rom_bit(rom_addr_b);
    rom_data_b <= rom_s1_b;
  end

  grid_lookup_arbiter #(.NUM_REQ(4), .ADDR_W(10), .ROM_LAT(1)) dut_a (
    .Clk        (clk),
    .Reset      (rst),
    .req        (req_a),
    .req_addr   (addr_a),
    .rsp_valid  (rsp_valid_a),
    .rsp_wall   (rsp_wall_a),
    .rom_addr   (rom_addr_a),
    .rom_data   (rom_data_a),
    .busy       (busy_a),
    .lookup_cnt (lookup_cnt_a),
    .wall_cnt   (wall_cnt_a)
  );

  grid_lookup_arbiter #(.NUM_REQ(4), .ADDR_W(10), .ROM_LAT(3)) dut_b (
    .Clk        (clk),
    .Reset      (rst),
    .req        (req_b),
    .req_addr   (addr_b),
    .rsp_valid  (rsp_valid_b),
    .rsp_wall   (rsp_wall_b),
    .rom_addr   (rom_addr_b),
    .rom_data   (rom_data_b),
    .busy       (busy_b),
    .lookup_cnt (lookup_cnt_b),
    .wall_cnt   (wall_cnt_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Single lookup on the ROM_LAT=1 instance; requester drops req after the pulse.
  task automatic do_lookup(input int idx, input logic [9:0] a, input logic exp_wall,
                           input logic [9:0] exp_rom);
    logic [3:0] oh;
    oh = 4'b0001 << idx;
    addr_a[idx*10 +: 10] = a;
    req_a = oh;
    if (a < 10'd768) begin
      step();
      check("lk_wait_valid", 32'(rsp_valid_a), 32'h0);
      check("lk_rom_addr", 32'(rom_addr_a), 32'(exp_rom));
      check("lk_busy", 32'(busy_a), 32'h1);
    end
    step();
    check("lk_grant", 32'(rsp_valid_a), 32'(oh));
    check("lk_wall", 32'(rsp_wall_a), 32'(exp_wall));
    check("lk_rom_hold", 32'(rom_addr_a), 32'(exp_rom));
    req_a = 4'b0000;
    step();
    check("lk_done_valid", 32'(rsp_valid_a), 32'h0);
    check("lk_done_busy", 32'(busy_a), 32'h0);
  endtask

  initial begin
    logic [3:0] rr_wall;
    rst    = 1'b1;
    req_a  = '0;
    addr_a = '0;
    req_b  = '0;
    addr_b = '0;
    step();
    step();

    check("rst_valid", 32'(rsp_valid_a), 32'h0);
    check("rst_wall", 32'(rsp_wall_a), 32'h0);
    check("rst_rom_addr", 32'(rom_addr_a), 32'h0);
    check("rst_busy", 32'(busy_a), 32'h0);
    check("rst_lookup_cnt", 32'(lookup_cnt_a), 32'h0);
    check("rst_wall_cnt", 32'(wall_cnt_a), 32'h0);
    check("rst_b_valid", 32'(rsp_valid_b), 32'h0);
    rst = 1'b0;
    step();

    // All four held from pointer 0: grants 0,1,2,3,0, one per three cycles.
    addr_a  = {10'd4, 10'd3, 10'd2, 10'd1};
    rr_wall = 4'b0101;
    req_a   = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      step();
      check("rr_wait_valid", 32'(rsp_valid_a), 32'h0);
      check("rr_rom_addr", 32'(rom_addr_a), 32'((k % 4) + 1));
      step();
      check("rr_grant", 32'(rsp_valid_a), 32'(4'b0001 << (k % 4)));
      check("rr_wall", 32'(rsp_wall_a), 32'(rr_wall[k % 4]));
      if (k == 4) req_a = 4'b0000;
      step();
      check("rr_gap", 32'(rsp_valid_a), 32'h0);
    end

    do_lookup(0, 10'd37, 1'b1, 10'd37);
    do_lookup(2, 10'd800, 1'b1, 10'd37);

    // Requester 1 drops req while its lookup is in flight.
    addr_a[10 +: 10] = 10'd5;
    req_a = 4'b0010;
    step();
    check("drop_busy", 32'(busy_a), 32'h1);
    req_a = 4'b0000;
    step();
    check("drop_grant", 32'(rsp_valid_a), 32'h2);
    check("drop_wall", 32'(rsp_wall_a), 32'h1);
    step();
    check("drop_idle", 32'(rsp_valid_a), 32'h0);

    // Reset during WAIT aborts the lookup.
    addr_a[30 +: 10] = 10'd6;
    req_a = 4'b1000;
    step();
    check("abort_busy", 32'(busy_a), 32'h1);
    check("abort_rom_addr", 32'(rom_addr_a), 32'd6);
    #2 rst = 1'b1;
    #1;
    check("abort_valid", 32'(rsp_valid_a), 32'h0);
    check("abort_wall", 32'(rsp_wall_a), 32'h0);
    check("abort_rom_zero", 32'(rom_addr_a), 32'h0);
    check("abort_busy_low", 32'(busy_a), 32'h0);
    req_a = 4'b0000;
    step();
    step();
    rst = 1'b0;
    for (int k = 0; k < 3; k++) begin
      step();
      check("abort_no_pulse", 32'(rsp_valid_a), 32'h0);
    end

    // First grant after reset goes to requester 0; five lookups, two walls.
    addr_a = {10'd800, 10'd4, 10'd2, 10'd7};
    req_a  = 4'b1111;
    step();
    check("post_rst_rom", 32'(rom_addr_a), 32'd7);
    step();
    check("post_rst_grant", 32'(rsp_valid_a), 32'h1);
    check("post_rst_wall", 32'(rsp_wall_a), 32'h1);
    req_a = 4'b0000;
    step();
    check("post_rst_idle", 32'(rsp_valid_a), 32'h0);
    do_lookup(1, 10'd2, 1'b0, 10'd2);
    do_lookup(2, 10'd4, 1'b0, 10'd4);
    do_lookup(3, 10'd800, 1'b1, 10'd4);
    do_lookup(0, 10'd0, 1'b0, 10'd0);
`ifdef GRID_ARB_STATS_EN
    check("stat_lookup_cnt", 32'(lookup_cnt_a), 32'd5);
    check("stat_wall_cnt", 32'(wall_cnt_a), 32'd2);
`else
    check("stat_lookup_cnt", 32'(lookup_cnt_a), 32'd0);
    check("stat_wall_cnt", 32'(wall_cnt_a), 32'd0);
`endif

    // ROM_LAT=3: free cell 0, then wall cell 37.
    addr_b[0 +: 10] = 10'd0;
    req_b = 4'b0001;
    step();
    check("lat3_busy", 32'(busy_b), 32'h1);
    check("lat3_wait1", 32'(rsp_valid_b), 32'h0);
    step();
    check("lat3_wait2", 32'(rsp_valid_b), 32'h0);
    step();
    check("lat3_wait3", 32'(rsp_valid_b), 32'h0);
    step();
    check("lat3_grant", 32'(rsp_valid_b), 32'h1);
    check("lat3_wall", 32'(rsp_wall_b), 32'h0);
    req_b = 4'b0000;
    step();
    check("lat3_idle", 32'(busy_b), 32'h0);
    addr_b[0 +: 10] = 10'd37;
    req_b = 4'b0001;
    step();
    step();
    step();
    check("lat3b_wait", 32'(rsp_valid_b), 32'h0);
    step();
    check("lat3b_grant", 32'(rsp_valid_b), 32'h1);
    check("lat3b_wall", 32'(rsp_wall_b), 32'h1);
    req_b = 4'b0000;
    step();
    check("lat3b_idle", 32'(rsp_valid_b), 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
